// File: rtl/fpu_dispatch_if.sv
// fpu_dispatch_if: request, FPU and writeback channels of the FPU dispatcher
//   req_*  : processor request channel (valid/ready)
//   fpu_*  : FPU start/done channel
//   wb_*   : writeback pulse with destination register and data
//   stall, err, err_clr : pipeline stall, sticky error and its clear
//   slave modport = dispatcher view, master modport = surrounding system view
interface fpu_dispatch_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        fpu_start;
    logic [1:0]  fpu_operation;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        err;
    logic        err_clr;
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, fpu_done, fpu_result, err_clr,
        output req_ready, fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid, wb_rd, wb_data, stall, err
    );
    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, fpu_done, fpu_result, err_clr,
        input  req_ready, fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid, wb_rd, wb_data, stall, err
    );
endinterface

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issues one processor FP request at a time to an FPU and writes the result back
//   clk   : sole clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : fpu_dispatch_if.slave (request, FPU start/done, writeback, stall, err/err_clr)
//   TIMEOUT_CYCLES : WAIT_DONE cycles before abort (only with FPU_DISPATCH_TIMEOUT_EN)
//   ACK_WAIT_MAX   : WAIT_ACK cycles with fpu_done still high before abort
//   Optional macro FPU_DISPATCH_TIMEOUT_EN enables the WAIT_DONE timeout.
module fpu_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ACK_WAIT_MAX   = 4
) (
    input logic          clk,
    input logic          reset,
    fpu_dispatch_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > ACK_WAIT_MAX) ? TIMEOUT_CYCLES : ACK_WAIT_MAX;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WB, ERR} state_t;
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        start_q, start_d, wb_valid_q, wb_valid_d;
    logic        ready_q, ready_d, stall_q, stall_d, err_q, err_d;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: if (bus.req_valid && ready_q) begin
                op_d    = bus.req_op;
                a_d     = bus.req_a;
                b_d     = bus.req_b;
                rd_d    = bus.req_rd;
                state_d = ISSUE;
            end
            // done seen during ISSUE is the FPU idling high, not a completion
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (!bus.fpu_done) begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end else if (cnt_q == CW'(ACK_WAIT_MAX - 1)) begin
                state_d = ERR;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WAIT_DONE: if (bus.fpu_done) begin
                wb_data_d = bus.fpu_result;
                wb_rd_d   = rd_q;
                state_d   = WB;
            end
`ifdef FPU_DISPATCH_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERR;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`endif
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        start_d    = (state_d == ISSUE) || (state_d == WAIT_ACK);
        wb_valid_d = state_d == WB;
        ready_d    = state_d == IDLE;
        stall_d    = state_d != IDLE;
        err_d      = (state_d == ERR) ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            start_q    <= start_d;
            wb_valid_q <= wb_valid_d;
            ready_q    <= ready_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end
    assign bus.req_ready     = ready_q;
    assign bus.fpu_start     = start_q;
    assign bus.fpu_operation = op_q;
    assign bus.fpu_a         = a_q;
    assign bus.fpu_b         = b_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.stall         = stall_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: randomized self-checking bench for fpu_dispatch with a writeback scoreboard
`timescale 1ns/1ps
module tb_fpu_dispatch;
    localparam int TO = 64, AW = 4, N = 16;
    typedef struct {logic [4:0] rd; logic [31:0] d;} wb_t;
    logic clk = 1'b0, reset = 1'b0;
    int n_chk = 0, n_err = 0, cyc = 0;
    wb_t exp_q[$];
    logic [1:0] ops[N];
    logic [31:0] as[N], bs[N], rs[N];
    logic [4:0] rds[N];
    bit hs[N];
    int acks[N], waits[N];
    fpu_dispatch_if bus();
    fpu_dispatch #(.TIMEOUT_CYCLES(TO), .ACK_WAIT_MAX(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    // every writeback pulse must match the oldest outstanding expected result
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("wb_unexpected", 32'(bus.wb_valid), 0);
            else begin
                chk("wb_rd", 32'(bus.wb_rd), 32'(exp_q[0].rd));
                chk("wb_data", bus.wb_data, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end
    task automatic chk_reset();
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_start", 32'(bus.fpu_start), 0);
        chk("rst_op", 32'(bus.fpu_operation), 0);
        chk("rst_a", bus.fpu_a, 0);
        chk("rst_b", bus.fpu_b, 0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_err", 32'(bus.err), 0);
    endtask
    task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
    endtask
    // one full transaction; hold keeps the next request on the bus while this one runs
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] r, input int ack_n, input int wait_n,
                          input bit hold, input logic [1:0] nop, input logic [31:0] na,
                          input logic [31:0] nb, input logic [4:0] nrd);
        int t0;
        wb_t e;
        present(op, a, b, rd);
        bus.fpu_done = 1'b1;
        chk("idle_ready", 32'(bus.req_ready), 1);
        chk("idle_stall", 32'(bus.stall), 0);
        step();
        t0 = cyc;
        if (hold) present(nop, na, nb, nrd);
        else bus.req_valid = 1'b0;
        chk("issue_start", 32'(bus.fpu_start), 1);
        chk("issue_ready", 32'(bus.req_ready), 0);
        chk("issue_stall", 32'(bus.stall), 1);
        chk("fpu_op", 32'(bus.fpu_operation), 32'(op));
        chk("fpu_a", bus.fpu_a, a);
        chk("fpu_b", bus.fpu_b, b);
        step();
        for (int k = 0; k < ack_n; k++) begin
            chk("ack_start", 32'(bus.fpu_start), 1);
            step();
        end
        chk("ack_start", 32'(bus.fpu_start), 1);
        bus.fpu_done = 1'b0;
        step();
        chk("done_start", 32'(bus.fpu_start), 0);
        for (int k = 0; k < wait_n; k++) begin
            chk("wait_stall", 32'(bus.stall), 1);
            chk("wait_a", bus.fpu_a, a);
            step();
        end
        bus.fpu_done = 1'b1;
        bus.fpu_result = r;
        e.rd = rd;
        e.d = r;
        exp_q.push_back(e);
        step();
        chk("wb_valid", 32'(bus.wb_valid), 1);
        chk("wb_stall", 32'(bus.stall), 1);
        chk("latency", 32'(cyc - t0), 32'(3 + ack_n + wait_n));
        bus.fpu_result = $urandom;
        step();
        chk("post_wb_valid", 32'(bus.wb_valid), 0);
        chk("post_stall", 32'(bus.stall), 0);
        chk("hold_data", bus.wb_data, r);
        chk("hold_rd", 32'(bus.wb_rd), 32'(rd));
        chk("kept_a", bus.fpu_a, a);
    endtask
    task automatic no_ack(input bit clr_held);
        int n;
        n = 0;
        present(2'($urandom), $urandom, $urandom, 5'($urandom));
        bus.fpu_done = 1'b1;
        bus.err_clr = clr_held;
        step();
        bus.req_valid = 1'b0;
        while (bus.fpu_start === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("start_len", 32'(n), 32'(1 + AW));
        chk("err_set", 32'(bus.err), 1);
        chk("err_stall", 32'(bus.stall), 1);
        step();
        chk("err_idle_stall", 32'(bus.stall), 0);
        chk("err_idle_ready", 32'(bus.req_ready), 1);
        chk("err_after", 32'(bus.err), clr_held ? 32'd0 : 32'd1);
        bus.err_clr = 1'b0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int n;
        wb_t e;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_rd = '0;
        bus.fpu_done = 1'b1;
        bus.fpu_result = '0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        reset = 1'b1;
        run_op(2'b00, 32'h3F800000, 32'h40000000, 5'd7, 32'h40400000, 0, 9, 1'b0, 2'b00, 0, 0, 5'd0);
        for (int i = 0; i < N; i++) begin
            ops[i] = 2'($urandom);
            as[i] = $urandom;
            bs[i] = $urandom;
            rs[i] = $urandom;
            rds[i] = 5'($urandom);
            hs[i] = (i < N - 1) ? 1'($urandom) : 1'b0;
            acks[i] = (i == 0) ? AW - 1 : $urandom_range(AW - 1, 0);
            waits[i] = (i == 0) ? 0 : $urandom_range(12, 0);
        end
        hs[1] = 1'b1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (i < N - 1) ? i + 1 : i;
            run_op(ops[i], as[i], bs[i], rds[i], rs[i], acks[i], waits[i], hs[i], ops[j], as[j], bs[j], rds[j]);
        end
        no_ack(1'b0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("err_cleared", 32'(bus.err), 0);
        step();
        chk("err_stays_clear", 32'(bus.err), 0);
        no_ack(1'b1);
        present(2'd1, 32'h12345678, 32'h9ABCDEF0, 5'd3);
        bus.fpu_done = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.fpu_done = 1'b0;
        step();
`ifdef FPU_DISPATCH_TIMEOUT_EN
        n = 0;
        while (bus.err !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("timeout_len", 32'(n), 32'(TO));
        chk("timeout_start", 32'(bus.fpu_start), 0);
        chk("timeout_stall", 32'(bus.stall), 1);
        step();
        chk("timeout_idle", 32'(bus.stall), 0);
        bus.fpu_done = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("timeout_clr", 32'(bus.err), 0);
`else
        n = 0;
        repeat (TO + 6) step();
        chk("notimeout_stall", 32'(bus.stall), 1);
        chk("notimeout_err", 32'(bus.err), 0);
        chk("notimeout_start", 32'(bus.fpu_start), 0);
        bus.fpu_done = 1'b1;
        bus.fpu_result = 32'hCAFEF00D;
        e.rd = 5'd3;
        e.d = 32'hCAFEF00D;
        exp_q.push_back(e);
        step();
        chk("notimeout_wb", 32'(bus.wb_valid), 1);
        step();
`endif
        no_ack(1'b0);
        present(2'd3, 32'hDEADBEEF, 32'h0BADF00D, 5'd9);
        bus.fpu_done = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.fpu_done = 1'b0;
        step();
        repeat (3) step();
        reset = 1'b0;
        bus.fpu_done = 1'b1;
        bus.fpu_result = 32'h55AA55AA;
        present(2'd2, 32'h11111111, 32'h22222222, 5'd17);
        step();
        chk_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        step();
        chk("post_rst_stall", 32'(bus.stall), 0);
        chk("post_rst_wb", 32'(bus.wb_valid), 0);
        run_op(2'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd31, 32'h0F0F0F0F, 1, 2, 1'b0, 2'd0, 0, 0, 5'd0);
        repeat (3) step();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
